// File: rtl/sys_ctrl_rx.sv
// sys_ctrl_rx: RX-side command-frame decoder of the system controller.
// Ports: CLK, rst (sync, active-high), RX_P_Data/RX_D_VLD byte input,
//   Rd_data_valid/ALU_OUT_valid completions, Address/WrEn/RdEn/WrData
//   to the register file, ALU_EN/ALU_FUN/CLK_GATE_EN to the ALU,
//   Frame_Err timeout pulse.
// Option: define FRAME_TIMEOUT_EN to abort stalled frames after
//   TIMEOUT_CYCLES idle cycles; otherwise Frame_Err is always 0.
module sys_ctrl_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_FUN_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    RX_P_Data,
  input  logic                     RX_D_VLD,
  input  logic                     Rd_data_valid,
  input  logic                     ALU_OUT_valid,
  output logic [ADDR_WIDTH-1:0]    Address,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic                     ALU_EN,
  output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
  output logic                     CLK_GATE_EN,
  output logic                     Frame_Err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  if (ADDR_WIDTH > DATA_WIDTH ||
      ALU_FUN_WIDTH > DATA_WIDTH) begin : g_bad_w
    $error("address/function width exceeds byte width");
  end

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_ALU_OPA,
    S_ALU_OPB,
    S_ALU_FUN,
    S_ALU_WAIT
  } state_t;

  state_t state;
  logic   tmo;

`ifdef FRAME_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          timed;

  always_comb begin
    timed = state inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR,
                          S_ALU_OPA, S_ALU_OPB, S_ALU_FUN};
  end

  // Fires on the edge that would make cnt equal TIMEOUT_CYCLES.
  assign tmo = timed && !RX_D_VLD &&
               (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (rst || RX_D_VLD || !timed)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (rst) begin
      state       <= S_IDLE;
      Address     <= '0;
      WrData      <= '0;
      ALU_FUN     <= '0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      Frame_Err   <= 1'b0;
    end else begin
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      ALU_EN    <= 1'b0;
      Frame_Err <= 1'b0;
      if (tmo) begin
        state       <= S_IDLE;
        Frame_Err   <= 1'b1;
        CLK_GATE_EN <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: if (RX_D_VLD) begin
            case (RX_P_Data)
              CMD_WR:  state <= S_WR_ADDR;
              CMD_RD:  state <= S_RD_ADDR;
              CMD_ALU: state <= S_ALU_OPA;
              CMD_FUN: begin
                state       <= S_ALU_FUN;
                CLK_GATE_EN <= 1'b1;
              end
              default: state <= S_IDLE;
            endcase
          end
          S_WR_ADDR: if (RX_D_VLD) begin
            Address <= RX_P_Data[ADDR_WIDTH-1:0];
            state   <= S_WR_DATA;
          end
          S_WR_DATA: if (RX_D_VLD) begin
            WrData <= RX_P_Data;
            WrEn   <= 1'b1;
            state  <= S_IDLE;
          end
          S_RD_ADDR: if (RX_D_VLD) begin
            Address <= RX_P_Data[ADDR_WIDTH-1:0];
            RdEn    <= 1'b1;
            state   <= S_RD_WAIT;
          end
          S_RD_WAIT: if (Rd_data_valid) begin
            state <= S_IDLE;
          end
          S_ALU_OPA: if (RX_D_VLD) begin
            Address <= '0;
            WrData  <= RX_P_Data;
            WrEn    <= 1'b1;
            state   <= S_ALU_OPB;
          end
          S_ALU_OPB: if (RX_D_VLD) begin
            Address     <= ADDR_WIDTH'(1);
            WrData      <= RX_P_Data;
            WrEn        <= 1'b1;
            state       <= S_ALU_FUN;
            CLK_GATE_EN <= 1'b1;
          end
          S_ALU_FUN: if (RX_D_VLD) begin
            ALU_FUN <= RX_P_Data[ALU_FUN_WIDTH-1:0];
            ALU_EN  <= 1'b1;
            state   <= S_ALU_WAIT;
          end
          S_ALU_WAIT: if (ALU_OUT_valid) begin
            state       <= S_IDLE;
            CLK_GATE_EN <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_ctrl_rx.sv
// tb_sys_ctrl_rx: directed self-checking bench for sys_ctrl_rx.
// Uses TIMEOUT_CYCLES=16; timeout vectors run when FRAME_TIMEOUT_EN is set.
module tb_sys_ctrl_rx;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] RX_P_Data = '0;
  logic       RX_D_VLD = 1'b0;
  logic       Rd_data_valid = 1'b0;
  logic       ALU_OUT_valid = 1'b0;
  logic [3:0] Address;
  logic       WrEn;
  logic       RdEn;
  logic [7:0] WrData;
  logic       ALU_EN;
  logic [3:0] ALU_FUN;
  logic       CLK_GATE_EN;
  logic       Frame_Err;

  int n_chk  = 0;
  int n_pass = 0;

  sys_ctrl_rx #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .ALU_FUN_WIDTH (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK          (CLK),
    .rst          (rst),
    .RX_P_Data    (RX_P_Data),
    .RX_D_VLD     (RX_D_VLD),
    .Rd_data_valid(Rd_data_valid),
    .ALU_OUT_valid(ALU_OUT_valid),
    .Address      (Address),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .WrData       (WrData),
    .ALU_EN       (ALU_EN),
    .ALU_FUN      (ALU_FUN),
    .CLK_GATE_EN  (CLK_GATE_EN),
    .Frame_Err    (Frame_Err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One byte, sampled on the next edge; consecutive calls are back-to-back.
  task automatic rx(input logic [7:0] b);
    RX_P_Data = b;
    RX_D_VLD  = 1'b1;
    step();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic strobes(input string tag,
                         input logic we, re, ae);
    chk({tag, ".wren"}, WrEn, we);
    chk({tag, ".rden"}, RdEn, re);
    chk({tag, ".alu_en"}, ALU_EN, ae);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    chk("rst.addr", Address, 0);
    chk("rst.wdata", WrData, 0);
    chk("rst.fun", ALU_FUN, 0);
    strobes("rst", 0, 0, 0);
    chk("rst.cg", CLK_GATE_EN, 0);
    chk("rst.ferr", Frame_Err, 0);
    rst = 1'b0;
    step();

    // register write
    rx(8'hAA);
    strobes("wr.cmd", 0, 0, 0);
    rx(8'h05);
    strobes("wr.adr", 0, 0, 0);
    rx(8'h3C);
    strobes("wr.dat", 1, 0, 0);
    chk("wr.addr", Address, 4'h5);
    chk("wr.wdata", WrData, 8'h3C);
    step();
    chk("wr.pulse", WrEn, 0);
    chk("wr.hold", WrData, 8'h3C);

    // register read, stray byte while waiting
    rx(8'hBB);
    rx(8'h02);
    strobes("rd", 0, 1, 0);
    chk("rd.addr", Address, 4'h2);
    step();
    chk("rd.pulse", RdEn, 0);
    rx(8'hAA);
    rx(8'h01);
    rx(8'h11);
    strobes("rd.stray", 0, 0, 0);
    Rd_data_valid = 1'b1;
    step();
    Rd_data_valid = 1'b0;
    rx(8'hAA);
    rx(8'h01);
    rx(8'h11);
    strobes("rd.next", 1, 0, 0);
    chk("rd.next.addr", Address, 4'h1);
    chk("rd.next.wdata", WrData, 8'h11);
    step();

    // ALU with operands
    rx(8'hCC);
    chk("alu.cmd.cg", CLK_GATE_EN, 0);
    rx(8'h07);
    strobes("alu.opa", 1, 0, 0);
    chk("alu.opa.addr", Address, 4'h0);
    chk("alu.opa.wdata", WrData, 8'h07);
    chk("alu.opa.cg", CLK_GATE_EN, 0);
    rx(8'h03);
    strobes("alu.opb", 1, 0, 0);
    chk("alu.opb.addr", Address, 4'h1);
    chk("alu.opb.wdata", WrData, 8'h03);
    chk("alu.opb.cg", CLK_GATE_EN, 1);
    rx(8'h01);
    strobes("alu.fun", 0, 0, 1);
    chk("alu.fun.val", ALU_FUN, 4'h1);
    chk("alu.fun.cg", CLK_GATE_EN, 1);
    step();
    chk("alu.wait.en", ALU_EN, 0);
    chk("alu.wait.cg", CLK_GATE_EN, 1);
    ALU_OUT_valid = 1'b1;
    step();
    ALU_OUT_valid = 1'b0;
    chk("alu.done.cg", CLK_GATE_EN, 0);
    chk("alu.done.fun", ALU_FUN, 4'h1);

    // unknown command, completion outside wait, reset mid-frame
    rx(8'h55);
    strobes("unk", 0, 0, 0);
    chk("unk.cg", CLK_GATE_EN, 0);
    ALU_OUT_valid = 1'b1;
    Rd_data_valid = 1'b1;
    step();
    ALU_OUT_valid = 1'b0;
    Rd_data_valid = 1'b0;
    rx(8'hAA);
    rx(8'h04);
    chk("mid.addr", Address, 4'h4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid.rst.addr", Address, 0);
    chk("mid.rst.wdata", WrData, 0);
    chk("mid.rst.fun", ALU_FUN, 0);
    rx(8'h99);
    strobes("mid.next", 0, 0, 0);
    step();
    chk("mid.next2.wren", WrEn, 0);

    // back-to-back, bytes dropped in ALU_WAIT
    rx(8'hDD);
    chk("b2b.cmd.cg", CLK_GATE_EN, 1);
    rx(8'h0A);
    strobes("b2b.fun", 0, 0, 1);
    chk("b2b.fun.val", ALU_FUN, 4'hA);
    chk("b2b.fun.cg", CLK_GATE_EN, 1);
    rx(8'hAA);
    rx(8'h02);
    rx(8'h33);
    strobes("b2b.drop", 0, 0, 0);
    chk("b2b.drop.cg", CLK_GATE_EN, 1);
    chk("b2b.drop.wdata", WrData, 8'h00);
    ALU_OUT_valid = 1'b1;
    step();
    ALU_OUT_valid = 1'b0;
    chk("b2b.done.cg", CLK_GATE_EN, 0);
    rx(8'hAA);
    rx(8'h03);
    rx(8'h44);
    strobes("b2b.wr", 1, 0, 0);
    chk("b2b.wr.wdata", WrData, 8'h44);
    rx(8'hBB);
    strobes("b2b.rdcmd", 0, 0, 0);
    rx(8'h06);
    strobes("b2b.rd", 0, 1, 0);
    chk("b2b.rd.addr", Address, 4'h6);
    Rd_data_valid = 1'b1;
    step();
    Rd_data_valid = 1'b0;

`ifdef FRAME_TIMEOUT_EN
    rx(8'hAA);
    rx(8'h03);
    for (int i = 0; i < 15; i++) step();
    chk("tmo.early", Frame_Err, 0);
    step();
    chk("tmo.err", Frame_Err, 1);
    strobes("tmo.err", 0, 0, 0);
    step();
    chk("tmo.pulse", Frame_Err, 0);
    rx(8'h44);
    strobes("tmo.after", 0, 0, 0);
    rx(8'hDD);
    for (int i = 0; i < 16; i++) step();
    chk("tmo.fun.err", Frame_Err, 1);
    chk("tmo.fun.cg", CLK_GATE_EN, 0);
`else
    rx(8'hAA);
    rx(8'h03);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("ferr.off", Frame_Err, 0);
    end
    rx(8'h44);
    strobes("ferr.off.wr", 1, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
